// File: rtl/rq_request_arbiter_if.sv
// Request/encoder bundle between the NVMe requesters, the arbiter and the TLP encoder.
`timescale 1ns/1ps
interface rq_request_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Handshake: a requester holds req_valid and its fields stable until it sees
    // req_ready (one-hot) high at a rising edge; that edge is the transfer. tx_start
    // is a one-cycle pulse and all tx_* fields stay stable until the tx_done pulse.
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [3*NUM_REQ-1:0]   req_type;
    logic [64*NUM_REQ-1:0]  req_addr;
    logic [128*NUM_REQ-1:0] req_data;
    logic [11*NUM_REQ-1:0]  req_length;
    logic [7:0]             req_tag;

    logic [2:0]             tx_type;
    logic [7:0]             tx_tag;
    logic [63:0]            tx_addr;
    logic [127:0]           tx_data;
    logic [10:0]            tx_length;
    logic                   tx_start;
    logic                   tx_done;

    modport master (
        output req_valid, req_type, req_addr, req_data, req_length, tx_done,
        input  req_ready, req_tag, tx_type, tx_tag, tx_addr, tx_data, tx_length, tx_start
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_data, req_length, tx_done,
        output req_ready, req_tag, tx_type, tx_tag, tx_addr, tx_data, tx_length, tx_start
    );
endinterface

// File: rtl/rq_request_arbiter.sv
// Round-robin scheduler sharing one TLP request encoder among NUM_REQ requesters,
// with read-tag allocation from a free-tag bitmap.
`timescale 1ns/1ps
module rq_request_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAGS = 16
) (
    input  logic                user_clk,
    input  logic                reset,
    rq_request_arbiter_if.slave rq,
    input  logic                tag_free_valid,
    input  logic [7:0]          tag_free_id,
    output logic [5:0]          tags_in_flight,
    output logic                bad_req,
    output logic                tag_err,
    output logic [1:0]          state_dbg
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [NUM_TAGS-1:0]  tag_alloc_q, tag_alloc_d, free_mask, alloc_mask;
    logic [NUM_REQ-1:0]   is_write, malformed, eligible;
    logic                 pool_empty, found, grant, alloc_en, free_ok;
    logic [PTR_W-1:0]     winner;
    logic [7:0]           free_tag;
    logic [5:0]           pop_d;
    logic [2:0]           win_type;
    logic [63:0]          win_addr;
    logic [127:0]         win_data;
    logic [10:0]          win_length;
    logic                 win_malformed;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return PTR_W'(s);
    endfunction

    assign pool_empty = &tag_alloc_q;

    // Malformed requests are still eligible so they can be drained and reported.
    always_comb begin
        is_write  = '0;
        malformed = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            is_write[i]  = rq.req_type[3*i];
            malformed[i] = rq.req_type[3*i+2]
                         | (rq.req_length[11*i +: 11] == 11'd0)
                         | (rq.req_type[3*i] & (rq.req_length[11*i +: 11] > 11'd4));
            eligible[i]  = rq.req_valid[i] & (is_write[i] | malformed[i] | ~pool_empty);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && eligible[wrap_idx(rr_ptr_q, k)]) begin
                found  = 1'b1;
                winner = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        win_type      = '0;
        win_addr      = '0;
        win_data      = '0;
        win_length    = '0;
        win_malformed = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_type      = rq.req_type[3*i +: 3];
                win_addr      = rq.req_addr[64*i +: 64];
                win_data      = rq.req_data[128*i +: 128];
                win_length    = rq.req_length[11*i +: 11];
                win_malformed = malformed[i];
            end
        end
    end

    // Lowest-index free tag; taken from the registered bitmap, so a tag freed
    // this cycle is only offered from the next cycle on.
    always_comb begin
        free_tag = 8'd0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!tag_alloc_q[t]) free_tag = 8'(t);
        end
    end

    assign grant    = (state_q == ST_IDLE) & found;
    assign alloc_en = grant & ~win_malformed & ~win_type[0];

    always_comb begin
        rq.req_ready = '0;
        if (grant) rq.req_ready = NUM_REQ'(1) << winner;
        rq.req_tag = alloc_en ? free_tag : 8'd0;
    end

    always_comb begin
        free_mask  = '0;
        alloc_mask = '0;
        pop_d      = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (tag_free_valid && tag_free_id == 8'(t) && tag_alloc_q[t]) free_mask[t] = 1'b1;
            if (alloc_en && free_tag == 8'(t)) alloc_mask[t] = 1'b1;
        end
        free_ok     = |free_mask;
        tag_alloc_d = (tag_alloc_q & ~free_mask) | alloc_mask;
        for (int t = 0; t < NUM_TAGS; t++) pop_d = pop_d + 6'(tag_alloc_d[t]);
    end

    always_ff @(posedge user_clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant && !win_malformed) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (rq.tx_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rq.tx_start = (state_q == ST_START);
        state_dbg   = state_q;
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            tag_alloc_q    <= '0;
            tags_in_flight <= '0;
            bad_req        <= 1'b0;
            tag_err        <= 1'b0;
            rq.tx_type     <= '0;
            rq.tx_tag      <= '0;
            rq.tx_addr     <= '0;
            rq.tx_data     <= '0;
            rq.tx_length   <= '0;
        end else begin
            tag_alloc_q    <= tag_alloc_d;
            tags_in_flight <= pop_d;
            bad_req        <= grant & win_malformed;
            tag_err        <= tag_free_valid & ~free_ok;
            if (grant) rr_ptr_q <= wrap_idx(winner, 1);
            if (grant && !win_malformed) begin
                rq.tx_type   <= win_type;
                rq.tx_tag    <= alloc_en ? free_tag : 8'd0;
                rq.tx_addr   <= win_addr;
                rq.tx_data   <= win_data;
                rq.tx_length <= win_length;
            end
        end
    end
endmodule

// File: tb/tb_rq_request_arbiter.sv
// Directed bench for rq_request_arbiter: a main driver thread, an encoder model
// and a monitor that pops grant/TLP expectations from queues.
`timescale 1ns/1ps
module tb_rq_request_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int NUM_TAGS = 16;
    localparam int TLP_W    = 3 + 8 + 64 + 128 + 11;
    localparam int BUDGET   = 600;

    logic user_clk = 1'b0;
    logic reset    = 1'b1;
    logic tag_free_valid = 1'b0;
    logic [7:0] tag_free_id = 8'h00;
    logic [5:0] tags_in_flight;
    logic bad_req, tag_err;
    logic [1:0] state_dbg;

    logic [NUM_REQ-1:0]     req_valid_v  = '0;
    logic [3*NUM_REQ-1:0]   req_type_v   = '0;
    logic [64*NUM_REQ-1:0]  req_addr_v   = '0;
    logic [128*NUM_REQ-1:0] req_data_v   = '0;
    logic [11*NUM_REQ-1:0]  req_length_v = '0;
    int refill [NUM_REQ];

    logic enc_done = 1'b0, stray_done = 1'b0, auto_done = 1'b1;

    logic [11:0]       exp_grant_q[$];
    logic [TLP_W-1:0]  exp_tlp_q[$];
    logic [NUM_REQ-1:0] mon_grant = '0;
    logic [TLP_W-1:0]  cap = '0;
    logic              cap_active = 1'b0;
    int                bad_cnt = 0;
    int                n_cmp = 0, n_fail = 0;

    rq_request_arbiter_if #(.NUM_REQ(NUM_REQ)) rq_if ();

    assign rq_if.req_valid  = req_valid_v;
    assign rq_if.req_type   = req_type_v;
    assign rq_if.req_addr   = req_addr_v;
    assign rq_if.req_data   = req_data_v;
    assign rq_if.req_length = req_length_v;
    assign rq_if.tx_done    = enc_done | stray_done;

    rq_request_arbiter #(.NUM_REQ(NUM_REQ), .NUM_TAGS(NUM_TAGS)) dut (
        .user_clk       (user_clk),
        .reset          (reset),
        .rq             (rq_if),
        .tag_free_valid (tag_free_valid),
        .tag_free_id    (tag_free_id),
        .tags_in_flight (tags_in_flight),
        .bad_req        (bad_req),
        .tag_err        (tag_err),
        .state_dbg      (state_dbg)
    );

    // clock / watchdog
    always #5 user_clk = ~user_clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // encoder model: done pulse two cycles after it sees tx_start
    initial begin
        forever begin
            @(negedge user_clk);
            if (rq_if.tx_start && auto_done && !reset) begin
                @(negedge user_clk);
                @(negedge user_clk);
                #1 enc_done = 1'b1;
                @(negedge user_clk);
                #1 enc_done = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge user_clk);
            mon_grant = rq_if.req_ready;
            if (reset) begin
                cap_active = 1'b0;
            end else begin
                if (rq_if.req_ready != '0) begin
                    if (exp_grant_q.size() == 0)
                        check("grant_unexpected", {rq_if.req_ready, rq_if.req_tag}, 12'h000);
                    else
                        check("grant", {rq_if.req_ready, rq_if.req_tag}, exp_grant_q.pop_front());
                end
                if (rq_if.tx_start) begin
                    cap = {rq_if.tx_type, rq_if.tx_tag, rq_if.tx_addr, rq_if.tx_data, rq_if.tx_length};
                    cap_active = 1'b1;
                    if (exp_tlp_q.size() == 0) check("tlp_unexpected", cap, '0);
                    else                       check("tlp", cap, exp_tlp_q.pop_front());
                end
                if (rq_if.tx_done && cap_active) begin
                    check("tx_stable", {rq_if.tx_type, rq_if.tx_tag, rq_if.tx_addr, rq_if.tx_data, rq_if.tx_length}, cap);
                    cap_active = 1'b0;
                end
                if (bad_req) bad_cnt++;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge user_clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mon_grant[i]) begin
                if (refill[i] > 0) refill[i]--;
                else               req_valid_v[i] = 1'b0;
            end
        end
    endtask

    task automatic post(input int i, input logic [2:0] t, input logic [63:0] a,
                        input logic [127:0] d, input logic [10:0] l, input int reps);
        req_type_v[3*i +: 3]     = t;
        req_addr_v[64*i +: 64]   = a;
        req_data_v[128*i +: 128] = d;
        req_length_v[11*i +: 11] = l;
        refill[i]                = reps;
        req_valid_v[i]           = 1'b1;
    endtask

    task automatic exp_grant(input int idx, input int tag);
        exp_grant_q.push_back({4'(1 << idx), 8'(tag)});
    endtask

    task automatic exp_tlp(input logic [2:0] t, input int tag, input logic [63:0] a,
                           input logic [127:0] d, input logic [10:0] l);
        exp_tlp_q.push_back({t, 8'(tag), a, d, l});
    endtask

    task automatic wait_grant(input int idx);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!mon_grant[idx] && n < BUDGET);
        check("grant_budget", 32'(n >= BUDGET), 32'd0);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((req_valid_v != '0 || exp_tlp_q.size() != 0 || cap_active) && n < BUDGET) begin
            step();
            n++;
        end
        step();
        step();
        check("drain_budget", 32'(n >= BUDGET), 32'd0);
        check("grants_left", 32'(exp_grant_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_tx"}, {rq_if.tx_type, rq_if.tx_tag, rq_if.tx_addr, rq_if.tx_data, rq_if.tx_length}, '0);
        check({name, "_ctl"}, {rq_if.req_ready, rq_if.req_tag, rq_if.tx_start, bad_req, tag_err,
                               tags_in_flight, state_dbg}, '0);
    endtask

    task automatic do_reset(input string name);
        reset          = 1'b1;
        req_valid_v    = '0;
        tag_free_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) refill[i] = 0;
        step();
        check_zero(name);
        step();
        reset = 1'b0;
    endtask

    task automatic free_tag(input logic [7:0] id);
        tag_free_valid = 1'b1;
        tag_free_id    = id;
        step();
        tag_free_valid = 1'b0;
    endtask

    // main sequence
    initial begin
        for (int i = 0; i < NUM_REQ; i++) refill[i] = 0;
        do_reset("rst0");

        // single posted write from requester 1
        exp_grant(1, 0);
        exp_tlp(3'b001, 0, 64'h1000, 128'hDEADBEEF, 11'd1);
        post(1, 3'b001, 64'h1000, 128'hDEADBEEF, 11'd1, 0);
        wait_grant(1);
        check("t1_start", {rq_if.tx_start, state_dbg}, {1'b1, 2'd1});
        step();
        check("t1_wait", {rq_if.tx_start, state_dbg}, {1'b0, 2'd2});
        wait_quiet();
        check("t1_tif", tags_in_flight, 6'd0);

        // four MemRd64 requesters, requester 0 asks twice
        do_reset("rst1");
        for (int i = 0; i < 4; i++) exp_grant(i, i);
        exp_grant(0, 4);
        for (int i = 0; i < 4; i++) exp_tlp(3'b010, i, 64'h2000 + 64'(i) * 64'h100, '0, 11'd1);
        exp_tlp(3'b010, 4, 64'h2000, '0, 11'd1);
        for (int i = 0; i < 4; i++) post(i, 3'b010, 64'h2000 + 64'(i) * 64'h100, '0, 11'd1, (i == 0) ? 1 : 0);
        wait_quiet();
        check("t2_tif", tags_in_flight, 6'd5);

        // exhaust the pool: tags 5..15
        for (int t = 5; t < 16; t++) begin
            exp_grant(0, t);
            exp_tlp(3'b010, t, 64'h3000, '0, 11'd1);
        end
        post(0, 3'b010, 64'h3000, '0, 11'd1, 10);
        wait_quiet();
        check("t3_tif_full", tags_in_flight, 6'd16);

        // read stalls on empty pool while a write passes it
        exp_grant(2, 0);
        exp_tlp(3'b001, 0, 64'h4000, 128'h1111_2222, 11'd1);
        post(0, 3'b010, 64'h5000, '0, 11'd2, 0);
        post(2, 3'b001, 64'h4000, 128'h1111_2222, 11'd1, 0);
        wait_grant(2);
        repeat (6) step();
        check("t3_stall", {state_dbg, rq_if.req_ready}, {2'd0, 4'b0000});
        exp_grant(0, 0);
        exp_tlp(3'b010, 0, 64'h5000, '0, 11'd2);
        free_tag(8'd0);
        check("t3_regrant", {rq_if.req_ready, rq_if.req_tag, tag_err}, {4'b0001, 8'd0, 1'b0});
        wait_quiet();
        check("t3_tif_after", tags_in_flight, 6'd16);

        // malformed requests: write length 5, then type 100
        exp_grant(1, 0);
        post(1, 3'b001, 64'h6000, '0, 11'd5, 0);
        wait_grant(1);
        check("t5_bad_len", {bad_req, rq_if.tx_start}, {1'b1, 1'b0});
        step();
        check("t5_bad_pulse", {bad_req, state_dbg}, {1'b0, 2'd0});
        exp_grant(2, 0);
        exp_tlp(3'b001, 0, 64'h7000, 128'h55, 11'd1);
        exp_grant(1, 0);
        post(1, 3'b100, 64'h6100, '0, 11'd1, 0);
        post(2, 3'b001, 64'h7000, 128'h55, 11'd1, 0);
        wait_quiet();
        check("t5_bad_cnt", 32'(bad_cnt), 32'd2);
        check("t5_tif", tags_in_flight, 6'd16);

        // bad frees, then reset during WAIT with three tags out
        do_reset("rst2");
        exp_grant(0, 0);
        exp_grant(1, 1);
        exp_tlp(3'b010, 0, 64'h8000, '0, 11'd4);
        exp_tlp(3'b010, 1, 64'h8100, '0, 11'd4);
        post(0, 3'b010, 64'h8000, '0, 11'd4, 0);
        post(1, 3'b010, 64'h8100, '0, 11'd4, 0);
        wait_quiet();
        check("t4_tif", tags_in_flight, 6'd2);
        free_tag(8'd5);
        check("t4_err_unalloc", tag_err, 1'b1);
        step();
        check("t4_err_pulse", {tag_err, tags_in_flight}, {1'b0, 6'd2});
        free_tag(8'h20);
        check("t4_err_range", {tag_err, tags_in_flight}, {1'b1, 6'd2});
        auto_done = 1'b0;
        exp_grant(2, 2);
        exp_tlp(3'b010, 2, 64'h8200, '0, 11'd1);
        post(2, 3'b010, 64'h8200, '0, 11'd1, 0);
        wait_grant(2);
        repeat (3) step();
        check("t6_wait", {state_dbg, tags_in_flight}, {2'd2, 6'd3});
        do_reset("rst3");
        auto_done = 1'b1;

        // stray tx_done while idle is ignored
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step();
        check("done_idle", {state_dbg, rq_if.tx_start}, {2'd0, 1'b0});

        exp_grant(0, 0);
        exp_tlp(3'b010, 0, 64'h9000, '0, 11'd1);
        post(0, 3'b010, 64'h9000, '0, 11'd1, 0);
        wait_quiet();
        check("t6_tif", tags_in_flight, 6'd1);
        check("tlps_left", 32'(exp_tlp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
